genie_code_table: RTL and testbench

- Parametrised successor to the Game Genie code store.
- Holds up to MAX_CODES address/compare/replace cheat entries.
- Entries are loaded, toggled, deleted or cleared through a valid/ready command port. A sequential scan FSM checks for duplicate addresses, so there is no wide comparator tree on the write path.
- Read-side override lookup stays combinational; it sits between CPU address/data bus and PRG read mux.

---
 rtl/genie_code_table_if.sv | 40 ++++
 rtl/genie_code_table.sv | 214 +++++++++++++++++++++
 tb/tb_genie_code_table.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/genie_code_table_if.sv
// Command port, CPU-side lookup bus and table status for the cheat code store.
// The slave modport is the table; the master modport is whoever drives commands and bus cycles.
interface genie_code_table_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 6
);
  logic              enable;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] data_in;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic              cmd_cmp_en;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_compare;
  logic [DATA_W-1:0] cmd_replace;
  logic              cmd_done;
  logic [1:0]        cmd_status;

  logic              genie_ovr;
  logic [DATA_W-1:0] genie_data;
  logic [CNT_W-1:0]  code_count;
  logic              table_full;

  modport slave (
    input  enable, addr_in, data_in,
    input  cmd_valid, cmd_op, cmd_cmp_en, cmd_addr, cmd_compare, cmd_replace,
    output cmd_ready, cmd_done, cmd_status,
    output genie_ovr, genie_data, code_count, table_full
  );

  modport master (
    output enable, addr_in, data_in,
    output cmd_valid, cmd_op, cmd_cmp_en, cmd_addr, cmd_compare, cmd_replace,
    input  cmd_ready, cmd_done, cmd_status,
    input  genie_ovr, genie_data, code_count, table_full
  );
endinterface

// File: rtl/genie_code_table.sv
// Cheat code store: load/delete take MAX_CODES+1 cycles (one slot scanned per cycle), clear/no-op take 1.
// Commands only accepted while idle (cmd_ready low otherwise); lookup override is combinational.
module genie_code_table #(
  parameter int MAX_CODES = 32,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int IDX_W     = $clog2(MAX_CODES)
) (
  input  logic                clk,
  input  logic                reset_n,
  genie_code_table_if.slave   bus
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_CODES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_CODES);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_DEL  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  localparam logic [1:0] ST_ADDED = 2'b00;
  localparam logic [1:0] ST_UPD   = 2'b01;
  localparam logic [1:0] ST_TOG   = 2'b10;
  localparam logic [1:0] ST_REJ   = 2'b11;

  typedef struct packed {
    logic              occ;
    logic              act;
    logic              cmp_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] cmp;
    logic [DATA_W-1:0] rep;
  } slot_t;

  typedef struct packed {
    logic [1:0]        op;
    logic              cmp_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] cmp;
    logic [DATA_W-1:0] rep;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT, S_CLEAR} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  slot_t             r_tab [MAX_CODES];
  cmd_t              r_cmd;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_match_idx;
  logic [IDX_W-1:0]  r_free_idx;
  logic              r_match_vld;
  logic              r_free_vld;
  logic              r_nop;
  logic              r_done;
  logic [1:0]        r_status;
  logic [CNT_W-1:0]  r_count;

  logic              w_ready;
  logic              w_accept;
  slot_t             w_scan_slot;
  slot_t             w_match_slot;
  slot_t             w_new_slot;
  logic              w_same;
  logic              w_ovr;
  logic [DATA_W-1:0] w_ovr_dat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_accept = 1'b1;
          case (bus.cmd_op)
            OP_LOAD, OP_DEL: w_state_nxt = S_SCAN;
            OP_CLR:          w_state_nxt = S_CLEAR;
            default:         w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_SCAN:   if (r_idx == LAST_IDX) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      S_CLEAR:  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_scan_slot       = r_tab[r_idx];
    w_match_slot      = r_tab[r_match_idx];
    w_new_slot        = '0;
    w_new_slot.occ    = 1'b1;
    w_new_slot.act    = 1'b1;
    w_new_slot.cmp_en = r_cmd.cmp_en;
    w_new_slot.addr   = r_cmd.addr;
    w_new_slot.cmp    = r_cmd.cmp;
    w_new_slot.rep    = r_cmd.rep;
    w_same = (w_match_slot.cmp_en == r_cmd.cmp_en) &&
             (w_match_slot.cmp == r_cmd.cmp) &&
             (w_match_slot.rep == r_cmd.rep);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_CODES; i++) r_tab[i] <= '0;
      r_cmd       <= '0;
      r_idx       <= '0;
      r_match_idx <= '0;
      r_free_idx  <= '0;
      r_match_vld <= 1'b0;
      r_free_vld  <= 1'b0;
      r_nop       <= 1'b0;
      r_done      <= 1'b0;
      r_status    <= ST_ADDED;
      r_count     <= '0;
    end else begin
      r_done <= r_nop;
      r_nop  <= w_accept && (bus.cmd_op == OP_NOP);
      if (r_nop) r_status <= ST_ADDED;

      if (w_accept) begin
        r_cmd.op     <= bus.cmd_op;
        r_cmd.cmp_en <= bus.cmd_cmp_en;
        r_cmd.addr   <= bus.cmd_addr;
        r_cmd.cmp    <= bus.cmd_compare;
        r_cmd.rep    <= bus.cmd_replace;
        r_idx        <= '0;
        r_match_vld  <= 1'b0;
        r_free_vld   <= 1'b0;
      end

      case (r_state)
        S_SCAN: begin
          r_idx <= r_idx + IDX_W'(1);
          if (w_scan_slot.occ && (w_scan_slot.addr == r_cmd.addr) && !r_match_vld) begin
            r_match_vld <= 1'b1;
            r_match_idx <= r_idx;
          end
          if (!w_scan_slot.occ && !r_free_vld) begin
            r_free_vld <= 1'b1;
            r_free_idx <= r_idx;
          end
        end
        S_COMMIT: begin
          r_done <= 1'b1;
          if (r_cmd.op == OP_LOAD) begin
            if (r_match_vld && w_same) begin
              r_tab[r_match_idx].act <= ~w_match_slot.act;
              r_status               <= ST_TOG;
            end else if (r_match_vld) begin
              r_tab[r_match_idx] <= w_new_slot;
              r_status           <= ST_UPD;
            end else if (r_free_vld) begin
              r_tab[r_free_idx] <= w_new_slot;
              r_count           <= r_count + CNT_W'(1);
              r_status          <= ST_ADDED;
            end else begin
              r_status <= ST_REJ;
            end
          end else if (r_match_vld) begin
            r_tab[r_match_idx].occ <= 1'b0;
            r_tab[r_match_idx].act <= 1'b0;
            r_count                <= r_count - CNT_W'(1);
            r_status               <= ST_UPD;
          end else begin
            r_status <= ST_REJ;
          end
        end
        S_CLEAR: begin
          for (int i = 0; i < MAX_CODES; i++) begin
            r_tab[i].occ <= 1'b0;
            r_tab[i].act <= 1'b0;
          end
          r_count  <= '0;
          r_done   <= 1'b1;
          r_status <= ST_UPD;
        end
        default: ;
      endcase
    end
  end

  // Walk from the top so the lowest-index hit is the one left standing.
  always_comb begin
    w_ovr     = 1'b0;
    w_ovr_dat = '0;
    for (int i = MAX_CODES - 1; i >= 0; i--) begin
      if (bus.enable && r_tab[i].occ && r_tab[i].act && (r_tab[i].addr == bus.addr_in) &&
          (!r_tab[i].cmp_en || (r_tab[i].cmp == bus.data_in))) begin
        w_ovr     = 1'b1;
        w_ovr_dat = r_tab[i].rep;
      end
    end
  end

  assign bus.cmd_ready  = w_ready;
  assign bus.cmd_done   = r_done;
  assign bus.cmd_status = r_status;
  assign bus.genie_ovr  = w_ovr;
  assign bus.genie_data = w_ovr_dat;
  assign bus.code_count = r_count;
  assign bus.table_full = (r_count == FULL_CNT);

endmodule

// File: tb/tb_genie_code_table.sv
// Directed bench for genie_code_table: command latency/status, lookup, fill/delete/reuse, reset abort, clear.
module tb_genie_code_table;
  localparam int MAX_CODES = 32;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 8;
  localparam int IDX_W     = $clog2(MAX_CODES);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  genie_code_table_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(IDX_W + 1)) bus ();

  genie_code_table #(
    .MAX_CODES(MAX_CODES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic cmp_en, input logic [15:0] addr,
                       input logic [7:0] cmp, input logic [7:0] rep);
    int guard = 0;
    @(negedge clk);
    while (!bus.cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.cmd_ready) check("ready_timeout", 32'd0, 32'd1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_cmp_en  = cmp_en;
    bus.cmd_addr    = addr;
    bus.cmd_compare = cmp;
    bus.cmd_replace = rep;
    @(posedge clk);
    #1;
    // Scramble the fields after acceptance: the table must use the latched copy.
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = ~op;
    bus.cmd_cmp_en  = ~cmp_en;
    bus.cmd_addr    = ~addr;
    bus.cmd_compare = ~cmp;
    bus.cmd_replace = ~rep;
  endtask

  task automatic wait_done(output int lat, output logic [1:0] st);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.cmd_done && lat < 200);
    st = bus.cmd_status;
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic cmp_en,
                         input logic [15:0] addr, input logic [7:0] cmp, input logic [7:0] rep,
                         input int exp_lat, input logic [1:0] exp_st);
    int         lat;
    logic [1:0] st;
    issue(op, cmp_en, addr, cmp, rep);
    wait_done(lat, st);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_st"}, {30'd0, st}, {30'd0, exp_st});
  endtask

  task automatic look(input string tag, input logic en, input logic [15:0] a, input logic [7:0] d,
                      input logic exp_ovr, input logic [7:0] exp_dat);
    @(negedge clk);
    bus.enable  = en;
    bus.addr_in = a;
    bus.data_in = d;
    #1;
    check({tag, "_ovr"}, {31'd0, bus.genie_ovr}, {31'd0, exp_ovr});
    check({tag, "_dat"}, {24'd0, bus.genie_data}, {24'd0, exp_dat});
  endtask

  localparam int LD = MAX_CODES + 1;

  initial begin
    int dones;
    bus.enable = 1'b1; bus.addr_in = '0; bus.data_in = '0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b11; bus.cmd_cmp_en = 1'b0;
    bus.cmd_addr = '0; bus.cmd_compare = '0; bus.cmd_replace = '0;

    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rst_done", {31'd0, bus.cmd_done}, 32'd0);
    check("rst_status", {30'd0, bus.cmd_status}, 32'd0);
    check("rst_count", {26'd0, bus.code_count}, 32'd0);
    check("rst_full", {31'd0, bus.table_full}, 32'd0);
    reset_n = 1'b1;

    run_cmd("load1", 2'b00, 1'b0, 16'h8123, 8'h00, 8'hA5, LD, 2'b00);
    check("load1_cnt", {26'd0, bus.code_count}, 32'd1);
    @(posedge clk); #1;
    check("done_pulse", {31'd0, bus.cmd_done}, 32'd0);
    check("status_hold", {30'd0, bus.cmd_status}, 32'd0);
    look("lk1", 1'b1, 16'h8123, 8'h5A, 1'b1, 8'hA5);
    look("lk1_miss", 1'b1, 16'h8124, 8'h5A, 1'b0, 8'h00);

    run_cmd("tog_off", 2'b00, 1'b0, 16'h8123, 8'h00, 8'hA5, LD, 2'b10);
    look("lk_off", 1'b1, 16'h8123, 8'h00, 1'b0, 8'h00);
    run_cmd("tog_on", 2'b00, 1'b0, 16'h8123, 8'h00, 8'hA5, LD, 2'b10);
    look("lk_on", 1'b1, 16'h8123, 8'h00, 1'b1, 8'hA5);

    run_cmd("cmp_load", 2'b00, 1'b1, 16'h9000, 8'h3C, 8'h11, LD, 2'b00);
    check("cmp_cnt", {26'd0, bus.code_count}, 32'd2);
    look("cmp_hit", 1'b1, 16'h9000, 8'h3C, 1'b1, 8'h11);
    look("cmp_miss", 1'b1, 16'h9000, 8'h3D, 1'b0, 8'h00);
    run_cmd("upd", 2'b00, 1'b0, 16'h9000, 8'h3C, 8'h22, LD, 2'b01);
    check("upd_cnt", {26'd0, bus.code_count}, 32'd2);
    look("upd_lk", 1'b1, 16'h9000, 8'h77, 1'b1, 8'h22);

    run_cmd("nop", 2'b11, 1'b0, 16'h0000, 8'h00, 8'h00, 1, 2'b00);
    check("nop_cnt", {26'd0, bus.code_count}, 32'd2);

    run_cmd("clr2", 2'b10, 1'b0, 16'h0000, 8'h00, 8'h00, 1, 2'b01);
    check("clr2_cnt", {26'd0, bus.code_count}, 32'd0);
    look("clr2_lk", 1'b1, 16'h9000, 8'h3C, 1'b0, 8'h00);

    for (int i = 0; i < MAX_CODES; i++)
      run_cmd("fill", 2'b00, 1'b0, 16'h1000 + 16'(i), 8'h00, 8'(i + 1), LD, 2'b00);
    check("fill_cnt", {26'd0, bus.code_count}, 32'd32);
    check("fill_full", {31'd0, bus.table_full}, 32'd1);
    look("fill_lk5", 1'b1, 16'h1005, 8'h00, 1'b1, 8'h06);

    run_cmd("rej", 2'b00, 1'b0, 16'h2000, 8'h00, 8'h44, LD, 2'b11);
    check("rej_cnt", {26'd0, bus.code_count}, 32'd32);
    run_cmd("del5", 2'b01, 1'b0, 16'h1005, 8'h00, 8'h00, LD, 2'b01);
    check("del5_cnt", {26'd0, bus.code_count}, 32'd31);
    check("del5_full", {31'd0, bus.table_full}, 32'd0);
    look("del5_lk", 1'b1, 16'h1005, 8'h00, 1'b0, 8'h00);
    run_cmd("del_miss", 2'b01, 1'b0, 16'h1005, 8'h00, 8'h00, LD, 2'b11);
    run_cmd("reuse", 2'b00, 1'b0, 16'h3000, 8'h00, 8'h99, LD, 2'b00);
    check("reuse_cnt", {26'd0, bus.code_count}, 32'd32);
    look("reuse_lk", 1'b1, 16'h3000, 8'h00, 1'b1, 8'h99);
    run_cmd("refull", 2'b00, 1'b0, 16'h3001, 8'h00, 8'h98, LD, 2'b11);

    issue(2'b00, 1'b0, 16'h4000, 8'h00, 8'h55);
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_done", {31'd0, bus.cmd_done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("mid_rst_cnt", {26'd0, bus.code_count}, 32'd0);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.cmd_done) dones++;
    end
    check("mid_rst_nodone", dones, 32'd0);
    look("mid_rst_lk", 1'b1, 16'h4000, 8'h00, 1'b0, 8'h00);
    look("mid_rst_lk2", 1'b1, 16'h1000, 8'h00, 1'b0, 8'h00);

    for (int i = 0; i < 10; i++)
      run_cmd("ten", 2'b00, 1'b0, 16'h5000 + 16'(i), 8'h00, 8'h80 + 8'(i), LD, 2'b00);
    check("ten_cnt", {26'd0, bus.code_count}, 32'd10);
    look("ten_lk", 1'b1, 16'h5003, 8'h00, 1'b1, 8'h83);
    run_cmd("clr10", 2'b10, 1'b0, 16'h0000, 8'h00, 8'h00, 1, 2'b01);
    check("clr10_cnt", {26'd0, bus.code_count}, 32'd0);
    look("clr10_lk0", 1'b1, 16'h5000, 8'h00, 1'b0, 8'h00);
    look("clr10_lk9", 1'b1, 16'h5009, 8'h00, 1'b0, 8'h00);

    run_cmd("en_load", 2'b00, 1'b0, 16'h6000, 8'h00, 8'hC3, LD, 2'b00);
    look("en_on", 1'b1, 16'h6000, 8'h00, 1'b1, 8'hC3);
    look("en_off", 1'b0, 16'h6000, 8'h00, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
